vref_step_ctrl: RTL

- System-side responder to the Vref training engine's step interface.
- Consumes vref_move / vref_direction / vref_reload and keeps the current Vref DAC code.
- Issues a req/ack transaction to the DAC for each code change, then waits a fixed settle time.
- Reports vref_out_of_range back to the trainer; an APB register window provides the reload value and status.

---
 rtl/vref_pkg.sv | 20 ++
 rtl/vref_step_ctrl_if.sv | 31 +++
 rtl/vref_apb_regs.sv | 82 ++++++++
 rtl/vref_step_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vref_pkg.sv
// Shared definitions for the Vref step controller.
// Holds the controller state encoding, the APB register offsets relative
// to APB_BASE, and the bit positions inside the status register.
package vref_pkg;

    typedef enum logic [1:0] {
        VREF_ST_IDLE   = 2'd0,
        VREF_ST_REQ    = 2'd1,
        VREF_ST_SETTLE = 2'd2
    } vref_state_t;

    localparam logic [15:0] VREF_REG_RELOAD = 16'd0;
    localparam logic [15:0] VREF_REG_CODE   = 16'd1;
    localparam logic [15:0] VREF_REG_STATUS = 16'd2;

    localparam int unsigned VREF_STAT_OOR  = 0;
    localparam int unsigned VREF_STAT_DROP = 1;
    localparam int unsigned VREF_STAT_BUSY = 2;

endpackage

// File: rtl/vref_step_ctrl_if.sv
// Bundle of trainer step, DAC handshake and APB signals for vref_step_ctrl.
//   master : trainer/system side (drives move/reload, dac_ack, APB requests)
//   slave  : vref_step_ctrl (drives code, dac_req, status, read data)
interface vref_step_ctrl_if #(
    parameter int VREF_WIDTH = 7
);
    logic                  vref_move;
    logic                  vref_direction;
    logic                  vref_reload;
    logic                  vref_out_of_range;
    logic                  vref_busy;
    logic [VREF_WIDTH-1:0] vref_code;
    logic                  dac_req;
    logic                  dac_ack;
    logic [15:0]           apb_addr;
    logic                  apb_we;
    logic [7:0]            apb_wrdata;
    logic [7:0]            vref_rddata;

    modport master (
        output vref_move, vref_direction, vref_reload, dac_ack,
               apb_addr, apb_we, apb_wrdata,
        input  vref_out_of_range, vref_busy, vref_code, dac_req, vref_rddata
    );

    modport slave (
        input  vref_move, vref_direction, vref_reload, dac_ack,
               apb_addr, apb_we, apb_wrdata,
        output vref_out_of_range, vref_busy, vref_code, dac_req, vref_rddata
    );
endinterface

// File: rtl/vref_apb_regs.sv
// APB register window of the Vref step controller.
//   +0 reload code (RW, writes clamped to [VREF_MIN, VREF_MAX])
//   +1 current code (RO)
//   +2 status: bit0 out_of_range, bit1 cmd_drop (write 1 clears), bit2 busy
// Ports: SCLK/reset, APB addr/we/wrdata in, live code/status in,
// cmd_drop_set pulse in, reload_code out, combinational rddata out.
module vref_apb_regs
    import vref_pkg::*;
#(
    parameter int          VREF_WIDTH   = 7,
    parameter int          VREF_DEFAULT = 64,
    parameter int          VREF_MIN     = 0,
    parameter int          VREF_MAX     = 127,
    parameter logic [15:0] APB_BASE     = 16'h0040
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic [15:0]           apb_addr,
    input  logic                  apb_we,
    input  logic [7:0]            apb_wrdata,
    input  logic [VREF_WIDTH-1:0] vref_code,
    input  logic                  out_of_range,
    input  logic                  busy,
    input  logic                  cmd_drop_set,
    output logic [VREF_WIDTH-1:0] reload_code,
    output logic [7:0]            rddata
);

    logic [VREF_WIDTH-1:0] reload_reg;
    logic                  cmd_drop;
    logic [VREF_WIDTH-1:0] wr_clamped;
    logic                  sel_reload;
    logic                  sel_code;
    logic                  sel_status;
    logic                  unused_wrdata;

    assign sel_reload    = (apb_addr == APB_BASE + VREF_REG_RELOAD);
    assign sel_code      = (apb_addr == APB_BASE + VREF_REG_CODE);
    assign sel_status    = (apb_addr == APB_BASE + VREF_REG_STATUS);
    assign reload_code   = reload_reg;
    assign unused_wrdata = ^apb_wrdata;

    always_comb begin
        wr_clamped = apb_wrdata[VREF_WIDTH-1:0];
        if (int'(wr_clamped) < VREF_MIN) begin
            wr_clamped = VREF_WIDTH'(VREF_MIN);
        end else if (int'(wr_clamped) > VREF_MAX) begin
            wr_clamped = VREF_WIDTH'(VREF_MAX);
        end
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            reload_reg <= VREF_WIDTH'(VREF_DEFAULT);
            cmd_drop   <= 1'b0;
        end else begin
            if (apb_we && sel_reload) begin
                reload_reg <= wr_clamped;
            end
            // A drop occurring in the same cycle as the clear must survive.
            if (cmd_drop_set) begin
                cmd_drop <= 1'b1;
            end else if (apb_we && sel_status && apb_wrdata[VREF_STAT_DROP]) begin
                cmd_drop <= 1'b0;
            end
        end
    end

    always_comb begin
        rddata = '0;
        if (sel_reload) begin
            rddata[VREF_WIDTH-1:0] = reload_reg;
        end else if (sel_code) begin
            rddata[VREF_WIDTH-1:0] = vref_code;
        end else if (sel_status) begin
            rddata[VREF_STAT_OOR]  = out_of_range;
            rddata[VREF_STAT_DROP] = cmd_drop;
            rddata[VREF_STAT_BUSY] = busy;
        end
    end

endmodule

// File: rtl/vref_step_ctrl.sv
// Vref step controller: responds to the training engine's move/reload
// requests, keeps the DAC code, runs one dac_req/dac_ack transaction per
// code change followed by a fixed settle time, and flags steps that would
// leave [VREF_MIN, VREF_MAX].
// Ports: SCLK, reset (async, active-high), bus (slave side of
// vref_step_ctrl_if: trainer step signals, DAC handshake, APB window).
module vref_step_ctrl
    import vref_pkg::*;
#(
    parameter int          VREF_WIDTH    = 7,
    parameter int          VREF_DEFAULT  = 64,
    parameter int          VREF_MIN      = 0,
    parameter int          VREF_MAX      = 127,
    parameter int          STEP_SIZE     = 1,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] APB_BASE      = 16'h0040
) (
    input logic           SCLK,
    input logic           reset,
    vref_step_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [VREF_WIDTH-1:0] STEP_C     = VREF_WIDTH'(STEP_SIZE);
    localparam logic [VREF_WIDTH:0]   STEP_X     = (VREF_WIDTH+1)'(STEP_SIZE);
    localparam logic [VREF_WIDTH:0]   MAX_X      = (VREF_WIDTH+1)'(VREF_MAX);
    localparam logic [VREF_WIDTH:0]   MIN_STEP_X = (VREF_WIDTH+1)'(VREF_MIN + STEP_SIZE);

    vref_state_t           state;
    logic [VREF_WIDTH-1:0] code;
    logic                  out_of_range;
    logic                  dac_req;
    logic [CNT_W-1:0]      settle_cnt;
    logic [VREF_WIDTH-1:0] reload_code;
    logic [VREF_WIDTH:0]   code_ext;
    logic                  up_blocked;
    logic                  dn_blocked;
    logic                  busy;
    logic                  cmd_drop_set;

    // Range checks in one extra bit so neither end can wrap.
    assign code_ext     = {1'b0, code};
    assign up_blocked   = (code_ext + STEP_X) > MAX_X;
    assign dn_blocked   = code_ext < MIN_STEP_X;
    assign busy         = (state != VREF_ST_IDLE);
    assign cmd_drop_set = busy && (bus.vref_move || bus.vref_reload);

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            state        <= VREF_ST_REQ;
            code         <= VREF_WIDTH'(VREF_DEFAULT);
            out_of_range <= 1'b0;
            dac_req      <= 1'b0;
            settle_cnt   <= '0;
        end else begin
            case (state)
                VREF_ST_IDLE: begin
                    if (bus.vref_reload) begin
                        code         <= reload_code;
                        out_of_range <= 1'b0;
                        dac_req      <= 1'b1;
                        state        <= VREF_ST_REQ;
                    end else if (bus.vref_move) begin
                        if (bus.vref_direction ? up_blocked : dn_blocked) begin
                            out_of_range <= 1'b1;
                        end else begin
                            code         <= bus.vref_direction ? code + STEP_C : code - STEP_C;
                            out_of_range <= 1'b0;
                            dac_req      <= 1'b1;
                            state        <= VREF_ST_REQ;
                        end
                    end
                end
                VREF_ST_REQ: begin
                    // Reset parks in REQ with dac_req low; the first clock
                    // raises it to push the default code. An ack only counts
                    // once the request is actually visible to the DAC.
                    if (!dac_req) begin
                        dac_req <= 1'b1;
                    end else if (bus.dac_ack) begin
                        dac_req    <= 1'b0;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        state      <= VREF_ST_SETTLE;
                    end
                end
                VREF_ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= VREF_ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= VREF_ST_IDLE;
                    dac_req <= 1'b0;
                end
            endcase
        end
    end

    vref_apb_regs #(
        .VREF_WIDTH  (VREF_WIDTH),
        .VREF_DEFAULT(VREF_DEFAULT),
        .VREF_MIN    (VREF_MIN),
        .VREF_MAX    (VREF_MAX),
        .APB_BASE    (APB_BASE)
    ) u_regs (
        .SCLK        (SCLK),
        .reset       (reset),
        .apb_addr    (bus.apb_addr),
        .apb_we      (bus.apb_we),
        .apb_wrdata  (bus.apb_wrdata),
        .vref_code   (code),
        .out_of_range(out_of_range),
        .busy        (busy),
        .cmd_drop_set(cmd_drop_set),
        .reload_code (reload_code),
        .rddata      (bus.vref_rddata)
    );

    assign bus.vref_code         = code;
    assign bus.vref_out_of_range = out_of_range;
    assign bus.vref_busy         = busy;
    assign bus.dac_req           = dac_req;

endmodule
